// File: rtl/bus_arbiter_mux_pkg.sv
// Shared definitions for the N-master bus arbiter: FSM encodings and the
// packed-bus offset helper used to slice per-master fields.
package bus_arbiter_mux_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // Bit offset of master idx within a bus packed as N fields of the given width.
  function automatic int unsigned pack_off(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping
// modulo N_MASTER, returned both one-hot and as an index.
module bus_rr_pick #(
  parameter int unsigned N_MASTER = 4,
  parameter int unsigned IDX_W    = $clog2(N_MASTER)
) (
  input  logic [N_MASTER-1:0] req,
  input  logic [IDX_W-1:0]    last,
  output logic [N_MASTER-1:0] winner,
  output logic [IDX_W-1:0]    winner_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = '0;
    // Scan last+1 .. last+N so the previous owner is considered last.
    for (int unsigned k = 1; k <= N_MASTER; k++) begin
      idx = IDX_W'((32'(last) + k) % N_MASTER);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        winner_idx  = idx;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// N-master shared-bus arbiter with round-robin grant, bounded hold time and a
// grant-steered address/write-data mux onto a single slave port.
module bus_arbiter_mux
  import bus_arbiter_mux_pkg::*;
#(
  parameter int unsigned N_MASTER = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_MASTER-1:0]        m_req,
  input  logic [N_MASTER-1:0]        m_we,
  input  logic [N_MASTER*ADDR_W-1:0] m_addr,
  input  logic [N_MASTER*DATA_W-1:0] m_wdata,
  output logic [N_MASTER-1:0]        m_grant,
  output logic                       s_sel,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [DATA_W-1:0]          s_rdata,
  output logic [DATA_W-1:0]          m_rdata
);

  localparam int unsigned IDX_W = $clog2(N_MASTER);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  logic                state_q, state_d;
  logic [N_MASTER-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    last_q, last_d;

  logic [N_MASTER-1:0] pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                others_req;
  logic                hold_max;

  bus_rr_pick #(
    .N_MASTER (N_MASTER),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req        (m_req),
    .last       (last_q),
    .winner     (pick),
    .winner_idx (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    others_req = |(m_req & ~grant_q);
    hold_max   = (cnt_q == CNT_W'(MAX_HOLD));
    case (state_q)
      ST_IDLE: begin
        if (|m_req) begin
          state_d = ST_GRANT;
          grant_d = pick;
          last_d  = pick_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        // Every release goes through IDLE, giving the bus one turnaround cycle.
        if (!(|(m_req & grant_q)) || (hold_max && others_req)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (!hold_max) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      last_q  <= IDX_W'(N_MASTER - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // AND-OR mux on the one-hot grant; an empty grant yields all zeros.
  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      s_we    = s_we | (m_we[i] & grant_q[i]);
      s_addr  = s_addr | (m_addr[pack_off(i, ADDR_W) +: ADDR_W] & {ADDR_W{grant_q[i]}});
      s_wdata = s_wdata | (m_wdata[pack_off(i, DATA_W) +: DATA_W] & {DATA_W{grant_q[i]}});
    end
  end

  assign m_grant = grant_q;
  assign s_sel   = |grant_q;
  assign m_rdata = s_rdata;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Scoreboard bench for bus_arbiter_mux: a behavioural arbiter model pushes the
// expected slave-side view each cycle, popped and compared after the edge.
module tb_bus_arbiter_mux;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MH = 8;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic          sel;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [AW-1:0]   addr_a [N];
  logic [DW-1:0]   wdata_a [N];
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_grant;
  logic            s_sel;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   s_rdata = '0;
  logic [DW-1:0]   m_rdata;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  int mdl_owner;
  int mdl_cnt;
  int mdl_last;

  logic [N-1:0] prev;
  int run, gap, held;
  int starts[$];
  int runs[$];
  int gaps[$];

  always #5 clk = ~clk;

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = addr_a[i];
      m_wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  bus_arbiter_mux #(
    .N_MASTER (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_req   (req),
    .m_we    (we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_grant (m_grant),
    .s_sel   (s_sel),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .m_rdata (m_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic mdl_reset();
    mdl_owner = -1;
    mdl_cnt   = 0;
    mdl_last  = N - 1;
  endtask

  // Arbiter behaviour at one rising edge, using the inputs currently driven.
  task automatic mdl_step();
    logic [N-1:0] others;
    if (mdl_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (mdl_last + k) % N;
        if (req[i]) begin
          mdl_owner = i;
          mdl_last  = i;
          mdl_cnt   = 1;
          break;
        end
      end
    end else begin
      others = req;
      others[mdl_owner] = 1'b0;
      if (!req[mdl_owner] || (mdl_cnt == MH && others != '0)) begin
        mdl_owner = -1;
        mdl_cnt   = 0;
      end else if (mdl_cnt < MH) begin
        mdl_cnt++;
      end
    end
  endtask

  function automatic exp_t mdl_expect();
    exp_t e;
    e = '0;
    if (mdl_owner >= 0) begin
      e.grant[mdl_owner] = 1'b1;
      e.sel   = 1'b1;
      e.we    = we[mdl_owner];
      e.addr  = addr_a[mdl_owner];
      e.wdata = wdata_a[mdl_owner];
    end
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    if (!reset_n) mdl_reset();
    else mdl_step();
    exp_q.push_back(mdl_expect());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_grant", 64'(m_grant), 64'(e.grant));
    check("sb_sel", 64'(s_sel), 64'(e.sel));
    check("sb_we", 64'(s_we), 64'(e.we));
    check("sb_addr", 64'(s_addr), 64'(e.addr));
    check("sb_wdata", 64'(s_wdata), 64'(e.wdata));
    check("sb_rdata", 64'(m_rdata), 64'(s_rdata));
  endtask

  initial begin
    mdl_reset();
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = AW'(8'h10 + i);
      wdata_a[i] = 32'hA000_0000 + i;
    end
    we      = 4'b0101;
    req     = '1;
    s_rdata = 32'hCAFE_0001;

    // Reset held with every master requesting: slave side stays quiet.
    #12;
    check("rst_grant", 64'(m_grant), 64'h0);
    check("rst_sel", 64'(s_sel), 64'h0);
    check("rst_addr", 64'(s_addr), 64'h0);
    check("rst_wdata", 64'(s_wdata), 64'h0);
    check("rst_we", 64'(s_we), 64'h0);
    check("rst_rdata", 64'(m_rdata), 64'hCAFE_0001);
    tick();
    reset_n = 1'b1;

    // All four request continuously: expect 0,1,2,3,0 with 8-cycle holds.
    tick();
    check("first_grant", 64'(m_grant), 64'h1);
    check("first_addr", 64'(s_addr), 64'h10);
    prev = m_grant;
    run  = 1;
    gap  = 0;
    starts.push_back(0);
    for (int c = 1; c < 40; c++) begin
      tick();
      if (m_grant != '0) begin
        if (m_grant != prev) begin
          starts.push_back($clog2(m_grant));
          gaps.push_back(gap);
          gap = 0;
          run = 1;
        end else begin
          run++;
        end
      end else begin
        if (prev != '0) runs.push_back(run);
        gap++;
      end
      prev = m_grant;
    end
    check("rr_nstarts", 64'(starts.size()), 64'd5);
    for (int k = 0; k < 5 && k < starts.size(); k++) check("rr_order", 64'(starts[k]), 64'(k % N));
    for (int k = 0; k < runs.size(); k++) check("rr_hold", 64'(runs[k]), 64'(MH));
    for (int k = 0; k < gaps.size(); k++) check("rr_gap", 64'(gaps[k]), 64'd1);
    req = '0;
    tick();
    tick();

    // Sole requester is never preempted.
    req  = 4'b0100;
    held = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_grant == 4'b0100) held++;
    end
    check("solo_held", 64'(held), 64'd20);
    req = '0;
    tick();
    check("solo_release", 64'(m_grant), 64'h0);

    // Datapath steering for master 1.
    addr_a[1]  = 8'h3C;
    wdata_a[1] = 32'hDEAD_BEEF;
    we[1]      = 1'b1;
    s_rdata    = 32'h1234_5678;
    req        = 4'b0010;
    tick();
    check("m1_grant", 64'(m_grant), 64'h2);
    check("m1_we", 64'(s_we), 64'h1);
    check("m1_addr", 64'(s_addr), 64'h3C);
    check("m1_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    check("m1_rdata", 64'(m_rdata), 64'h1234_5678);
    req = '0;
    tick();

    // Asynchronous reset mid-grant.
    req = 4'b1000;
    tick();
    check("m3_grant", 64'(m_grant), 64'h8);
    #2 reset_n = 1'b0;
    #1;
    check("async_grant", 64'(m_grant), 64'h0);
    check("async_sel", 64'(s_sel), 64'h0);
    check("async_addr", 64'(s_addr), 64'h0);
    mdl_reset();
    req = 4'b1001;
    #2 reset_n = 1'b1;
    tick();
    check("post_rst_win", 64'(m_grant), 64'h1);

    // Release with 1 and 3 waiting: one idle cycle, then 1, later 3 not 0.
    req = 4'b1010;
    tick();
    check("turn_idle", 64'(m_grant), 64'h0);
    tick();
    check("turn_m1", 64'(m_grant), 64'h2);
    req = 4'b1001;
    tick();
    check("turn_idle2", 64'(m_grant), 64'h0);
    tick();
    check("turn_m3", 64'(m_grant), 64'h8);

    // Random traffic; requests tend to persist so preemption gets exercised.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      we = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        addr_a[i]  = AW'($urandom);
        wdata_a[i] = $urandom;
      end
      s_rdata = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised N-master shared-bus arbiter and datapath multiplexer; successor to the two-master 32-bit grant-selected bus mux. Accepts requests from `N_MASTER` masters, grants the bus round-robin with a bounded hold time, and steers the granted master's address, write data and write-enable onto a single slave port. Read data is broadcast back to all masters. Sits between the masters and the memory/slave decode logic in the bus subsystem.

## Interface
- `N_MASTER`, 4: number of masters, 2..8.
- `ADDR_W`, 8: address width.
- `DATA_W`, 32: data width.
- `MAX_HOLD`, 8: maximum consecutive grant cycles before forced release when another master is waiting; ≥1.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m_req`  in  N_MASTER  per-master bus request, level-sensitive.
- `m_we`  in  N_MASTER  per-master write enable.
- `m_addr`  in  N_MASTER*ADDR_W  packed addresses; master i at bits [i*ADDR_W +: ADDR_W].
- `m_wdata`  in  N_MASTER*DATA_W  packed write data; same packing.
- `m_grant`  out  N_MASTER  registered one-hot grant; all-zero when idle.
- `s_sel`  out  1  slave select; high when any grant is active.
- `s_we`  out  1  muxed write enable; forced 0 when no grant.
- `s_addr`  out  ADDR_W  muxed address; 0 when no grant.
- `s_wdata`  out  DATA_W  muxed write data; 0 when no grant.
- `s_rdata`  in  DATA_W  slave read data.
- `m_rdata`  out  DATA_W  `s_rdata` passed through combinationally to all masters.

## Operation
- Two-state FSM: IDLE (no grant), GRANT (exactly one `m_grant` bit set).
- Round-robin pointer `last` holds the index of the most recently granted master.
- IDLE: if any `m_req` bit is high, grant the first requester searching `last+1, last+2, …` modulo N_MASTER. Go to GRANT, load `last`, set hold count to 1. Otherwise stay in IDLE.
- GRANT, hold count `cnt`:
  - If the granted master's `m_req` is low, clear the grant and go to IDLE.
  - Else if `cnt == MAX_HOLD` and any other master requests, clear the grant and go to IDLE (preemption).
  - Else keep the grant and increment `cnt`, saturating at MAX_HOLD.
- Every release passes through at least one IDLE cycle (bus turnaround). Grants never move directly from one master to another.
- Datapath: `s_we`, `s_addr` and `s_wdata` are selected combinationally from `m_grant`. With no grant they are driven to 0, never X.
- `cnt` width is $clog2(MAX_HOLD+1); `last` width is $clog2(N_MASTER).

## Timing
- Reset (asynchronous, `reset_n` low): state IDLE, `m_grant`=0, `cnt`=0, `last`=N_MASTER-1 so master 0 wins first. Consequently `s_sel`=0, `s_we`=0, `s_addr`=0, `s_wdata`=0. `m_rdata` follows `s_rdata` even during reset.
- Grant latency: `m_req[i]` high at rising edge t while in IDLE → `m_grant[i]` high after edge t. Slave outputs reflect master i in the same cycle.
- Release: `m_req[i]` sampled low at edge t → `m_grant`=0 after t. The earliest regrant is after edge t+1.
- Preemption: a master holding continuously with a competitor waiting owns the bus for exactly MAX_HOLD cycles, then gets 1 idle cycle.
- Simultaneous requests: resolved by round-robin order only; index order has no fixed priority beyond the pointer.
- Request dropped and re-raised in the IDLE cycle: treated as a new request and competes normally.
- Reset asserted mid-grant: grant drops immediately (asynchronously) and the pointer returns to N_MASTER-1.

## Structure
- Shared package/include: state encodings `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1, plus the packing-offset helper.
- One sub-module, `bus_rr_pick`:
  - combinational;
  - inputs are the request vector and `last`;
  - output is the one-hot winner and its index.
- FSM, counter and datapath mux live in the top module.

## Test plan
- Reset with all `m_req`=1 → all outputs 0. After release, master 0 is granted on the first edge, with `s_addr`=`m_addr[0]`.
- N_MASTER=4, all four request continuously, MAX_HOLD=8 → grants cycle 0,1,2,3,0. Each grant lasts 8 cycles, followed by 1 idle cycle.
- Only master 2 requests for 20 cycles → grant held for all 20 cycles (no preemption), `cnt` saturates at 8. Drop `m_req[2]` → idle on the next edge.
- Master 1 is granted with `m_we`=1, `m_addr`=8'h3C, `m_wdata`=32'hDEADBEEF → slave port shows exactly those values. `m_rdata` equals `s_rdata`=32'h12345678 on all masters.
- Master 3 granted, `reset_n` pulsed low between clock edges → `m_grant`=0 and `s_sel`=0 immediately. After reset, with masters 0 and 3 requesting → master 0 wins.
- Master 0 releases while masters 1 and 3 request → exactly 1 idle cycle, then master 1 is granted. At the next release master 3 is granted, not master 0.
